// File: rtl/io_bus_router_if.sv
// io_bus bundle between the core, the router and the peripheral targets.
// Latency: none, wires only.
// Backpressure: none; the bus is strobe based and every access completes.
interface io_bus_router_if #(
    parameter int NUM_TARGETS = 4
) ();
    logic                      host_read_en;
    logic                      host_write_en;
    logic [31:0]               host_address;
    logic [31:0]               host_write_data;
    logic [31:0]               host_read_data;
    logic [NUM_TARGETS-1:0]    tgt_read_en;
    logic [NUM_TARGETS-1:0]    tgt_write_en;
    logic [31:0]               tgt_address;
    logic [31:0]               tgt_write_data;
    logic [NUM_TARGETS*32-1:0] tgt_read_data;

    // Router side: takes host strobes and target read data, fans out strobes.
    modport slave (
        input  host_read_en, host_write_en, host_address, host_write_data, tgt_read_data,
        output host_read_data, tgt_read_en, tgt_write_en, tgt_address, tgt_write_data
    );

    // Environment side: the core plus the targets.
    modport master (
        output host_read_en, host_write_en, host_address, host_write_data, tgt_read_data,
        input  host_read_data, tgt_read_en, tgt_write_en, tgt_address, tgt_write_data
    );
endinterface

// File: rtl/io_bus_router.sv
// Base/mask io_bus decoder onto N targets, plus local output regs and an unmapped-access recorder.
// Latency: strobes and broadcast are combinational; read data valid one cycle after host_read_en.
// Backpressure: none; every access completes in its own cycle.
module io_bus_router #(
    parameter int                           NUM_TARGETS    = 4,
    parameter logic [NUM_TARGETS*32-1:0]    TARGET_BASE    = {32'h240, 32'h180, 32'hc0, 32'h40},
    parameter logic [NUM_TARGETS*32-1:0]    TARGET_MASK    = {NUM_TARGETS{32'hffff_ffc0}},
    parameter int                           NUM_LOCAL_REGS = 6,
    parameter logic [31:0]                  LOCAL_BASE     = 32'h0,
    parameter logic [NUM_LOCAL_REGS*32-1:0] LOCAL_RESET    = '0
) (
    input  logic                        clk,
    input  logic                        reset,
    io_bus_router_if.slave              bus,
    output logic [NUM_LOCAL_REGS*32-1:0] local_out,
    output logic [15:0]                 unmapped_count,
    output logic [31:0]                 unmapped_addr
);
    localparam int TIDX_W = (NUM_TARGETS > 1) ? $clog2(NUM_TARGETS) : 1;
    localparam int LIDX_W = (NUM_LOCAL_REGS > 1) ? $clog2(NUM_LOCAL_REGS) : 1;
    localparam int IDX_W  = (TIDX_W > LIDX_W) ? TIDX_W : LIDX_W;
    localparam logic [31:0] LOCAL_SPAN = 32'(4 * NUM_LOCAL_REGS);

    typedef enum logic [1:0] {
        SEL_NONE  = 2'd0,
        SEL_LOCAL = 2'd1,
        SEL_TGT   = 2'd2
    } sel_kind_e;

    logic [32:0]            local_off;
    logic                   local_hit;
    logic [LIDX_W-1:0]      local_idx;
    logic                   tgt_hit;
    logic [TIDX_W-1:0]      tgt_idx;
    logic [NUM_TARGETS-1:0] tgt_sel;
    logic                   unmapped_hit;

    logic [31:0] local_q [NUM_LOCAL_REGS];
    logic [31:0] local_d [NUM_LOCAL_REGS];
    sel_kind_e   rd_kind_q, rd_kind_d;
    logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
    logic [15:0] unm_cnt_q, unm_cnt_d;
    logic [31:0] unm_addr_q, unm_addr_d;
    logic [31:0] rd_dat;

    // 33-bit offset: bit 32 set means the address lies below LOCAL_BASE.
    always_comb begin
        local_off = {1'b0, bus.host_address} - {1'b0, LOCAL_BASE};
        local_hit = (bus.host_address[1:0] == 2'b00) && !local_off[32]
                    && (local_off[31:0] < LOCAL_SPAN);
        local_idx = local_off[LIDX_W+1:2];
    end

    // Scan from the top so the lowest matching index is the one left standing.
    always_comb begin
        tgt_hit = 1'b0;
        tgt_idx = '0;
        for (int i = NUM_TARGETS - 1; i >= 0; i--) begin
            if ((bus.host_address & TARGET_MASK[32*i +: 32]) == TARGET_BASE[32*i +: 32]) begin
                tgt_hit = 1'b1;
                tgt_idx = TIDX_W'(i);
            end
        end
        tgt_sel = '0;
        if (tgt_hit && !local_hit) begin
            tgt_sel[tgt_idx] = 1'b1;
        end
    end

    assign unmapped_hit = (bus.host_read_en || bus.host_write_en) && !local_hit && !tgt_hit;

    assign bus.tgt_read_en    = {NUM_TARGETS{bus.host_read_en}} & tgt_sel;
    assign bus.tgt_write_en   = {NUM_TARGETS{bus.host_write_en}} & tgt_sel;
    assign bus.tgt_address    = bus.host_address;
    assign bus.tgt_write_data = bus.host_write_data;

    always_comb begin
        local_d    = local_q;
        rd_kind_d  = rd_kind_q;
        rd_idx_d   = rd_idx_q;
        unm_cnt_d  = unm_cnt_q;
        unm_addr_d = unm_addr_q;

        for (int k = 0; k < NUM_LOCAL_REGS; k++) begin
            if (bus.host_write_en && local_hit && (local_idx == LIDX_W'(k))) begin
                local_d[k] = bus.host_write_data;
            end
        end

        if (bus.host_read_en) begin
            if (local_hit) begin
                rd_kind_d = SEL_LOCAL;
                rd_idx_d  = IDX_W'(local_idx);
            end else if (tgt_hit) begin
                rd_kind_d = SEL_TGT;
                rd_idx_d  = IDX_W'(tgt_idx);
            end else begin
                rd_kind_d = SEL_NONE;
                rd_idx_d  = '0;
            end
        end

        if (unmapped_hit) begin
            if (unm_cnt_q != 16'hffff) begin
                unm_cnt_d = unm_cnt_q + 16'd1;
            end
            unm_addr_d = bus.host_address;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NUM_LOCAL_REGS; k++) begin
                local_q[k] <= LOCAL_RESET[32*k +: 32];
            end
            rd_kind_q  <= SEL_NONE;
            rd_idx_q   <= '0;
            unm_cnt_q  <= 16'h0;
            unm_addr_q <= 32'h0;
        end else begin
            local_q    <= local_d;
            rd_kind_q  <= rd_kind_d;
            rd_idx_q   <= rd_idx_d;
            unm_cnt_q  <= unm_cnt_d;
            unm_addr_q <= unm_addr_d;
        end
    end

    // Local reads return the register as it stands after the read cycle, so a
    // same-cycle write is already visible; target reads stay live.
    always_comb begin
        rd_dat = 32'h0;
        case (rd_kind_q)
            SEL_LOCAL: begin
                for (int k = 0; k < NUM_LOCAL_REGS; k++) begin
                    if (rd_idx_q == IDX_W'(k)) begin
                        rd_dat = local_q[k];
                    end
                end
            end
            SEL_TGT: begin
                for (int i = 0; i < NUM_TARGETS; i++) begin
                    if (rd_idx_q == IDX_W'(i)) begin
                        rd_dat = bus.tgt_read_data[32*i +: 32];
                    end
                end
            end
            default: rd_dat = 32'h0;
        endcase
    end

    assign bus.host_read_data = rd_dat;

    for (genvar k = 0; k < NUM_LOCAL_REGS; k++) begin : g_local_out
        assign local_out[32*k +: 32] = local_q[k];
    end

    assign unmapped_count = unm_cnt_q;
    assign unmapped_addr  = unm_addr_q;
endmodule
